// File: rtl/mem_reader.sv
// mem_reader: fetches one frame of DEPTH words from a 1-cycle-latency ROM and
// streams them out through a small show-ahead pixel FIFO with valid/ready
// handshaking. ROM reads are throttled so that the FIFO can never overflow,
// whatever back-pressure the pixel consumer applies.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   start_in       one-cycle request to fetch a frame (honoured only in IDLE)
//   rom_addr_out   registered ROM read address
//   rom_rd_en_out  registered ROM read enable
//   rom_dat_in     ROM data, valid the cycle after a rom_rd_en_out cycle
//   pix_rdy_in     pixel consumer ready
//   pix_vld_out    FIFO not empty
//   pix_dat_out    FIFO head (show-ahead), zero while pix_vld_out is low
//   busy_out       high while the FSM is not idle
//   frame_done_out one-cycle pulse on the pop of the last word of the frame
//   uflow_out      sticky underflow flag
//
// Build option: define MEM_READER_UFLOW_DET_EN to enable underflow detection
// (consumer ready while the FIFO is empty during a frame). Without it
// uflow_out is tied to 0.

module mem_reader #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  output logic [$clog2(DEPTH)-1:0] rom_addr_out,
  output logic                     rom_rd_en_out,
  input  logic [WIDTH-1:0]         rom_dat_in,
  input  logic                     pix_rdy_in,
  output logic                     pix_vld_out,
  output logic [WIDTH-1:0]         pix_dat_out,
  output logic                     busy_out,
  output logic                     frame_done_out,
  output logic                     uflow_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;  // occupancy 0..FIFO_DEPTH
  localparam int unsigned SW = PW + 2;  // occupancy plus reads in flight

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] next_addr_q, next_addr_d;  // next address to issue
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_en_q, rd_en_d;
  logic          resp_vld_q;                 // rom_dat_in valid this cycle

  logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    pop_cnt_q;

  logic          push, pop, last_pop, issue;
  logic [SW-1:0] committed;

  // Handshake and flow-control decode.
  always_comb begin
    push        = resp_vld_q;
    pix_vld_out = (count_q != '0);
    pop         = pix_vld_out & pix_rdy_in;
    last_pop    = pop && (pop_cnt_q == AW'(DEPTH - 1));
    count_d     = count_q + CW'(push) - CW'(pop);
    // Entries the FIFO is committed to after this edge: current occupancy,
    // the response landing now, the read issued last cycle, minus this pop.
    // A new read is only issued if it still fits.
    committed   = SW'(count_q) + SW'(resp_vld_q) + SW'(rd_en_q) - SW'(pop);
    issue       = (state_q == StFetch) && (committed < SW'(FIFO_DEPTH));
  end

  // FSM next-state and registered ROM request.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    addr_d      = '0;
    rd_en_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_in) state_d = StFetch;
      end
      StFetch: begin
        if (issue) begin
          rd_en_d     = 1'b1;
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + AW'(1);  // wraps to 0 after DEPTH-1
          if (next_addr_q == AW'(DEPTH - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      next_addr_q <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      resp_vld_q  <= 1'b0;  // drops any response still due from the ROM
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      resp_vld_q  <= rd_en_q;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        pop_cnt_q <= pop_cnt_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= rom_dat_in;
  end

  always_comb begin
    rom_addr_out   = addr_q;
    rom_rd_en_out  = rd_en_q;
    pix_dat_out    = pix_vld_out ? fifo_q[rd_ptr_q] : '0;
    busy_out       = (state_q != StIdle);
    frame_done_out = last_pop;
  end

`ifdef MEM_READER_UFLOW_DET_EN
  logic uflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      uflow_q <= 1'b0;
    end else if ((state_q != StIdle) && pix_rdy_in && !pix_vld_out) begin
      uflow_q <= 1'b1;
    end
  end

  assign uflow_out = uflow_q;
`else
  assign uflow_out = 1'b0;
`endif

endmodule
